receptor_hamming_serial: RTL and testbench
==========================================

Name: receptor_hamming_serial

Overview:
- Receiving end of the serial link that carries 8-bit extended-Hamming (SECDED) codewords produced by the encoder.
- Deserializes one UART-style frame, computes syndrome and overall parity, corrects single errors and flags double errors.
- Presents the decoded 4-bit data, the corrected word and the status flags to the display/LED logic.

Parameters:
- CICLOS_POR_BIT, 4, clock cycles per serial bit; legal range ≥2.

Ports:
- reloj  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- dato_serial  input  1  serial line; idle high.
- dato_salida  output  4  corrected data {d4,d3,d2,d1}.
- palabra_corregida  output  8  codeword after correction.
- sindrome  output  4  {st,s3,s2,s1} of the last frame.
- valido  output  1  one-cycle pulse when a frame has been decoded.
- error_simple  output  1  last frame had a single error (corrected).
- error_doble  output  1  last frame had a double error (not corrected).
- error_trama  output  1  one-cycle pulse on bad stop bit or false start.
- ocupado  output  1  high while a frame is in progress.

Behaviour:
- Reset: all outputs 0; FSM to REPOSO; synchronizer flops set to 1. Reset mid-frame discards the partial frame, and no pulse is emitted.
- dato_serial passes through a 2-flop synchronizer before any use; all timing below refers to the synchronized line.
- Frame format: start bit 0, 8 bits LSB (bit 0) first, stop bit 1.
- Codeword map: b[0]=p1, b[1]=p2, b[2]=d1, b[3]=p4, b[4]=d2, b[5]=d3, b[6]=d4, b[7]=pt (even parity over b[6:0]).
- FSM states and transitions:
  - REPOSO: on a synchronized 0, go to INICIO and clear the bit-timer.
  - INICIO: at timer = CICLOS_POR_BIT/2 (integer division), sample the line. If the sample is 1 (false start), pulse error_trama and go to REPOSO. Otherwise go to DATOS with the bit index at 0.
  - DATOS: sample every CICLOS_POR_BIT cycles and shift into b[index]. After index 7, go to PARADA.
  - PARADA: sample after CICLOS_POR_BIT cycles. If the sample is 0, pulse error_trama; data outputs and flags are unchanged; go to REPOSO. If the sample is 1, go to DECODIFICAR.
  - DECODIFICAR: exactly one cycle. Registers the results, pulses valido, then goes to REPOSO.
- ocupado = 1 in every state except REPOSO.
- Syndrome equations:
  - s1 = b0^b2^b4^b6
  - s2 = b1^b2^b5^b6
  - s3 = b3^b4^b5^b6
  - st = XOR of b[7:0]
  - S = {s3,s2,s1}
- Error classification:
  - S=0, st=0: no error; both flags 0.
  - st=1: single error; error_simple=1. If S≠0, invert b[S-1]. If S=0, invert b[7].
  - S≠0, st=0: double error; error_doble=1; word passed uncorrected.
- dato_salida = {b6,b5,b4,b2} of the corrected word.
- dato_salida, palabra_corregida, sindrome, error_simple and error_doble are updated only in DECODIFICAR and hold until the next decoded frame.
- Latency: valido is asserted in the cycle after the stop-bit sample.
- A new start bit is accepted starting the cycle REPOSO is re-entered (back-to-back frames supported).

Optional Feature:
- Macro CONTADOR_ERRORES_EN.
- Defined: adds outputs cuenta_simples[7:0] and cuenta_dobles[7:0].
  - Each increments in DECODIFICAR when the corresponding flag is set.
  - Both saturate at 8'hFF and are cleared by reset.
- Undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Clean frame 8'h55 (dato 4'b1011) -> valido pulse; dato_salida=4'b1011, palabra_corregida=8'h55, sindrome=4'h0, both flags 0.
- Frame 8'h45 (b4 flipped) -> error_simple=1, sindrome=4'hD, palabra_corregida=8'h55, dato_salida=4'b1011.
- Frame 8'hD5 (pt flipped) -> error_simple=1, sindrome=4'h8, palabra_corregida=8'h55. Frame 8'h56 (b0,b1 flipped) -> error_doble=1, sindrome=4'h3, palabra_corregida=8'h56.
- Stop bit driven 0 on 8'h55 -> error_trama pulse, no valido, outputs keep the previous frame's values. 1-cycle low glitch on an idle line -> error_trama pulse, FSM returns to REPOSO.
- reset asserted during DATOS bit 4 -> all outputs 0, no pulse. Subsequent 8'h55 frame decodes correctly. Two back-to-back frames -> two valido pulses exactly 10·CICLOS_POR_BIT cycles apart.
- With CONTADOR_ERRORES_EN: 3 single-error frames + 1 double-error frame -> cuenta_simples=3, cuenta_dobles=1. 300 single-error frames -> cuenta_simples=8'hFF.

Source files
------------

// File: rtl/receptor_hamming_serial_if.sv
// Signal bundle between the serial Hamming receiver and its user (display/LED logic).
// CONTADOR_ERRORES_EN adds the saturating error counter outputs.
interface receptor_hamming_serial_if;
    logic       dato_serial;
    logic [3:0] dato_salida;
    logic [7:0] palabra_corregida;
    logic [3:0] sindrome;
    logic       valido;
    logic       error_simple;
    logic       error_doble;
    logic       error_trama;
    logic       ocupado;
`ifdef CONTADOR_ERRORES_EN
    logic [7:0] cuenta_simples;
    logic [7:0] cuenta_dobles;
`endif

`ifdef CONTADOR_ERRORES_EN
    modport slave (
        input  dato_serial,
        output dato_salida, palabra_corregida, sindrome, valido,
        output error_simple, error_doble, error_trama, ocupado,
        output cuenta_simples, cuenta_dobles
    );
    modport master (
        output dato_serial,
        input  dato_salida, palabra_corregida, sindrome, valido,
        input  error_simple, error_doble, error_trama, ocupado,
        input  cuenta_simples, cuenta_dobles
    );
`else
    modport slave (
        input  dato_serial,
        output dato_salida, palabra_corregida, sindrome, valido,
        output error_simple, error_doble, error_trama, ocupado
    );
    modport master (
        output dato_serial,
        input  dato_salida, palabra_corregida, sindrome, valido,
        input  error_simple, error_doble, error_trama, ocupado
    );
`endif
endinterface

// File: rtl/receptor_hamming_serial.sv
// UART-style receiver for 8-bit extended Hamming (SECDED) codewords: deserialize, correct, flag.
// Optional macro CONTADOR_ERRORES_EN adds saturating single/double error counters.
module receptor_hamming_serial #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic                        reloj,
    input  logic                        reset,
    receptor_hamming_serial_if.slave    bus
);
    localparam int TW = $clog2(CICLOS_POR_BIT + 1);
    // The detection cycle in REPOSO counts as the first cycle of the half bit.
    localparam logic [TW-1:0] MITAD = TW'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [TW-1:0] FIN   = TW'(CICLOS_POR_BIT - 1);

    localparam logic [2:0] REPOSO      = 3'd0;
    localparam logic [2:0] INICIO      = 3'd1;
    localparam logic [2:0] DATOS       = 3'd2;
    localparam logic [2:0] PARADA      = 3'd3;
    localparam logic [2:0] DECODIFICAR = 3'd4;

    logic          r_sync0, r_sync1;
    logic          w_linea;
    logic [2:0]    r_estado;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_idx;
    logic [7:0]    r_b;

    logic [3:0]    r_dato;
    logic [7:0]    r_palabra;
    logic [3:0]    r_sindrome;
    logic          r_valido, r_simple, r_doble, r_trama;

    logic          w_s1, w_s2, w_s3, w_st;
    logic [2:0]    w_s;
    logic [7:0]    w_mascara, w_corr;

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= bus.dato_serial;
            r_sync1 <= r_sync0;
        end
    end
    assign w_linea = r_sync1;

    assign w_s1 = r_b[0] ^ r_b[2] ^ r_b[4] ^ r_b[6];
    assign w_s2 = r_b[1] ^ r_b[2] ^ r_b[5] ^ r_b[6];
    assign w_s3 = r_b[3] ^ r_b[4] ^ r_b[5] ^ r_b[6];
    assign w_st = ^r_b;
    assign w_s  = {w_s3, w_s2, w_s1};

    // Odd overall parity means one flipped bit; S=0 then points at the parity bit itself.
    always_comb begin
        w_mascara = 8'h00;
        if (w_st) begin
            if (w_s != 3'd0) w_mascara = 8'(1) << (w_s - 3'd1);
            else             w_mascara = 8'h80;
        end
    end
    assign w_corr = r_b ^ w_mascara;

`ifdef CONTADOR_ERRORES_EN
    logic [7:0] r_cuenta_s, r_cuenta_d;

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_cuenta_s <= 8'h00;
            r_cuenta_d <= 8'h00;
        end else if (r_estado == DECODIFICAR) begin
            if (w_st && r_cuenta_s != 8'hFF)
                r_cuenta_s <= r_cuenta_s + 8'd1;
            if (!w_st && w_s != 3'd0 && r_cuenta_d != 8'hFF)
                r_cuenta_d <= r_cuenta_d + 8'd1;
        end
    end
    assign bus.cuenta_simples = r_cuenta_s;
    assign bus.cuenta_dobles  = r_cuenta_d;
`endif

    always_ff @(posedge reloj) begin
        if (reset) begin
            r_estado   <= REPOSO;
            r_timer    <= '0;
            r_idx      <= 3'd0;
            r_b        <= 8'h00;
            r_dato     <= 4'h0;
            r_palabra  <= 8'h00;
            r_sindrome <= 4'h0;
            r_valido   <= 1'b0;
            r_simple   <= 1'b0;
            r_doble    <= 1'b0;
            r_trama    <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            r_trama  <= 1'b0;
            case (r_estado)
                REPOSO: begin
                    if (!w_linea) begin
                        r_estado <= INICIO;
                        r_timer  <= '0;
                    end
                end
                INICIO: begin
                    if (r_timer == MITAD) begin
                        if (w_linea) begin
                            r_trama  <= 1'b1;
                            r_estado <= REPOSO;
                        end else begin
                            r_estado <= DATOS;
                            r_idx    <= 3'd0;
                            r_timer  <= '0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DATOS: begin
                    if (r_timer == FIN) begin
                        r_timer    <= '0;
                        r_b[r_idx] <= w_linea;
                        if (r_idx == 3'd7) r_estado <= PARADA;
                        else               r_idx    <= r_idx + 3'd1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                PARADA: begin
                    if (r_timer == FIN) begin
                        r_timer <= '0;
                        if (w_linea) begin
                            r_estado <= DECODIFICAR;
                        end else begin
                            r_trama  <= 1'b1;
                            r_estado <= REPOSO;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DECODIFICAR: begin
                    r_palabra  <= w_corr;
                    r_dato     <= {w_corr[6], w_corr[5], w_corr[4], w_corr[2]};
                    r_sindrome <= {w_st, w_s};
                    r_simple   <= w_st;
                    r_doble    <= !w_st && (w_s != 3'd0);
                    r_valido   <= 1'b1;
                    r_estado   <= REPOSO;
                end
                default: r_estado <= REPOSO;
            endcase
        end
    end

    assign bus.dato_salida       = r_dato;
    assign bus.palabra_corregida = r_palabra;
    assign bus.sindrome          = r_sindrome;
    assign bus.valido            = r_valido;
    assign bus.error_simple      = r_simple;
    assign bus.error_doble       = r_doble;
    assign bus.error_trama       = r_trama;
    assign bus.ocupado           = (r_estado != REPOSO);
endmodule

// File: tb/tb_receptor_hamming_serial.sv
// Directed bench for receptor_hamming_serial: table of codewords plus framing/reset corner cases.
module tb_receptor_hamming_serial;
    localparam int C = 4;

    typedef struct {
        logic [7:0] palabra;
        logic [3:0] dato;
        logic [7:0] corr;
        logic [3:0] sind;
        logic       simple;
        logic       doble;
    } vec_t;

    logic reloj = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_valido = 0, n_trama = 0, cyc = 0, t_last = 0, t_prev = 0;

    receptor_hamming_serial_if bus ();

    receptor_hamming_serial #(.CICLOS_POR_BIT(C)) dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    always #5 reloj = ~reloj;

    always @(negedge reloj) begin
        cyc <= cyc + 1;
        if (bus.valido) begin
            n_valido <= n_valido + 1;
            t_prev   <= t_last;
            t_last   <= cyc;
        end
        if (bus.error_trama) n_trama <= n_trama + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nombre, act, exp);
        end
    endtask

    task automatic bit_serie(input logic v);
        bus.dato_serial = v;
        repeat (C) @(negedge reloj);
    endtask

    task automatic enviar(input logic [7:0] w, input logic stop);
        bit_serie(1'b0);
        for (int i = 0; i < 8; i++) bit_serie(w[i]);
        bit_serie(stop);
    endtask

    task automatic esperar_valido(input int previo, input string nombre);
        int n;
        n = 0;
        while (n_valido == previo && n < 30) begin
            @(negedge reloj);
            n++;
        end
        chk({nombre, " valido"}, n_valido, previo + 1);
    endtask

    task automatic chk_salidas(input string nombre, input logic [3:0] d, input logic [7:0] p,
                               input logic [3:0] s, input logic es, input logic ed);
        chk({nombre, " dato"},    bus.dato_salida, d);
        chk({nombre, " palabra"}, bus.palabra_corregida, p);
        chk({nombre, " sindrome"}, bus.sindrome, s);
        chk({nombre, " simple"},  bus.error_simple, es);
        chk({nombre, " doble"},   bus.error_doble, ed);
    endtask

    vec_t tabla [9];

    initial begin
        int pv, pt;
        tabla[0] = '{8'h55, 4'hB, 8'h55, 4'h0, 1'b0, 1'b0};
        tabla[1] = '{8'h45, 4'hB, 8'h55, 4'hD, 1'b1, 1'b0};
        tabla[2] = '{8'hD5, 4'hB, 8'h55, 4'h8, 1'b1, 1'b0};
        tabla[3] = '{8'h56, 4'hB, 8'h56, 4'h3, 1'b0, 1'b1};
        tabla[4] = '{8'h00, 4'h0, 8'h00, 4'h0, 1'b0, 1'b0};
        tabla[5] = '{8'hFF, 4'hF, 8'hFF, 4'h0, 1'b0, 1'b0};
        tabla[6] = '{8'hFB, 4'hF, 8'hFF, 4'hB, 1'b1, 1'b0};
        tabla[7] = '{8'h40, 4'h0, 8'h00, 4'hF, 1'b1, 1'b0};
        tabla[8] = '{8'h81, 4'h0, 8'h81, 4'h1, 1'b0, 1'b1};

        bus.dato_serial = 1'b1;
        repeat (3) @(negedge reloj);
        chk_salidas("reset", 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        chk("reset valido", bus.valido, 1'b0);
        chk("reset trama", bus.error_trama, 1'b0);
        chk("reset ocupado", bus.ocupado, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge reloj);
        chk("idle ocupado", bus.ocupado, 1'b0);

        for (int i = 0; i < 9; i++) begin
            pv = n_valido;
            enviar(tabla[i].palabra, 1'b1);
            esperar_valido(pv, $sformatf("v%0d", i));
            chk_salidas($sformatf("v%0d", i), tabla[i].dato, tabla[i].corr,
                        tabla[i].sind, tabla[i].simple, tabla[i].doble);
        end

        // Bad stop bit: outputs must keep the 0x81 double-error results.
        pv = n_valido;
        pt = n_trama;
        enviar(8'h55, 1'b0);
        bus.dato_serial = 1'b1;
        repeat (3 * C + 10) @(negedge reloj);
        chk("stop0 no valido", n_valido, pv);
        chk("stop0 trama", n_trama > pt, 1'b1);
        chk_salidas("stop0 hold", 4'h0, 8'h81, 4'h1, 1'b0, 1'b1);
        chk("stop0 ocupado", bus.ocupado, 1'b0);

        // One-cycle low glitch on the idle line is a false start.
        pv = n_valido;
        pt = n_trama;
        bus.dato_serial = 1'b0;
        @(negedge reloj);
        bus.dato_serial = 1'b1;
        repeat (10) @(negedge reloj);
        chk("glitch trama", n_trama, pt + 1);
        chk("glitch no valido", n_valido, pv);
        chk("glitch ocupado", bus.ocupado, 1'b0);

        // Reset in the middle of data bit 4.
        pv = n_valido;
        pt = n_trama;
        bit_serie(1'b0);
        for (int i = 0; i < 4; i++) bit_serie(tabla[0].palabra[i]);
        bus.dato_serial = tabla[0].palabra[4];
        repeat (C / 2) @(negedge reloj);
        chk("midframe ocupado", bus.ocupado, 1'b1);
        reset = 1'b1;
        bus.dato_serial = 1'b1;
        repeat (2) @(negedge reloj);
        reset = 1'b0;
        repeat (12 * C) @(negedge reloj);
        chk_salidas("midreset", 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        chk("midreset ocupado", bus.ocupado, 1'b0);
        chk("midreset no valido", n_valido, pv);
        chk("midreset no trama", n_trama, pt);

        pv = n_valido;
        enviar(8'h55, 1'b1);
        esperar_valido(pv, "post reset");
        chk_salidas("post reset", 4'hB, 8'h55, 4'h0, 1'b0, 1'b0);

        // Back-to-back frames: valido pulses exactly one frame apart.
        pv = n_valido;
        enviar(8'h55, 1'b1);
        enviar(8'hFF, 1'b1);
        esperar_valido(pv + 1, "b2b");
        chk("b2b spacing", t_last - t_prev, 10 * C);
        chk_salidas("b2b", 4'hF, 8'hFF, 4'h0, 1'b0, 1'b0);

`ifdef CONTADOR_ERRORES_EN
        chk("cnt simples start", bus.cuenta_simples, 8'd0);
        chk("cnt dobles start", bus.cuenta_dobles, 8'd0);
        enviar(8'h45, 1'b1);
        enviar(8'hD5, 1'b1);
        enviar(8'hFB, 1'b1);
        enviar(8'h56, 1'b1);
        repeat (20) @(negedge reloj);
        chk("cnt simples 3", bus.cuenta_simples, 8'd3);
        chk("cnt dobles 1", bus.cuenta_dobles, 8'd1);
        for (int i = 0; i < 300; i++) enviar(8'h40, 1'b1);
        repeat (20) @(negedge reloj);
        chk("cnt simples sat", bus.cuenta_simples, 8'hFF);
        chk("cnt dobles hold", bus.cuenta_dobles, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
